sram_port_sequencer: RTL

Front-end sequencer for the two-port `sram_array` bank. It accepts binary read/write requests over a valid/ready handshake. It then drives the bank's one-hot word lines, data input, `ReadEn` and `WriteEn` in lock-step with the 10-phase Bennett clock (`clkp`). For reads, it captures `outA`/`outB` and returns them as a one-cycle response.

---
 rtl/sram_port_sequencer.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_port_sequencer.sv
// sram_port_sequencer
//
// Front-end sequencer for the two-port sram_array bank. A binary read/write
// request is accepted over a valid/ready handshake. It is then walked through
// the bank's word-line / data / enable sequence in lock-step with the 10-phase
// Bennett clock (clkp). Reads return the captured bank outputs with a one-cycle
// rsp_valid pulse.
//
// Optional feature: define SRAM_SEQ_TIMEOUT_EN to enable a phase watchdog.
// The watchdog aborts a stalled transaction after TIMEOUT clk cycles and
// pulses rsp_err. Without the macro, rsp_err is tied to 0 and the sequencer
// waits for phases indefinitely.
//
// Ports:
//   clk                  system clock (also drives bennett_clock)
//   reset                asynchronous active-high reset
//   clkp[9:0]            Bennett phase vector
//   req_valid/req_ready  request handshake (ready = idle)
//   req_write            1 = write, 0 = read
//   req_addrA/req_addrB  binary port addresses
//   req_data             write data
//   rsp_valid            one-cycle completion pulse
//   rsp_dataA/rsp_dataB  captured read data (held until the next read)
//   rsp_err              watchdog abort pulse
//   wordA/wordB          one-hot word lines to the bank
//   sram_in              bank data input
//   ReadEn/WriteEn       bank enables
//   outA/outB            bank read data

module sram_port_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 32,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       clkp,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addrA,
  input  logic [AW-1:0]    req_addrB,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_dataA,
  output logic [WIDTH-1:0] rsp_dataB,
  output logic             rsp_err,
  output logic [DEPTH-1:0] wordA,
  output logic [DEPTH-1:0] wordB,
  output logic [WIDTH-1:0] sram_in,
  output logic             ReadEn,
  output logic             WriteEn,
  input  logic [WIDTH-1:0] outA,
  input  logic [WIDTH-1:0] outB
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ADDR,
    DATA,
    EN,
    HOLD
  } state_t;

  localparam logic [DEPTH-1:0] WORD_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  state_t state, state_d;

  logic [9:0]       clkp_q;
  logic [9:0]       rise;
  logic [9:0]       wait_mask;
  logic             awaited;
  logic             accept;
  logic             tmo_hit;

  logic             write_q;
  logic [AW-1:0]    addr_a_q;
  logic [AW-1:0]    addr_b_q;
  logic [WIDTH-1:0] data_q;

  logic [DEPTH-1:0] word_a_d, word_b_d;
  logic [WIDTH-1:0] sram_in_d;
  logic             read_en_d, write_en_d, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_a_d, rsp_data_b_d;

  assign rise = clkp & ~clkp_q;

  // The idle cycle that carries rsp_valid is not allowed to accept. This keeps
  // a response and a new accept out of the same cycle.
  assign req_ready = (state == IDLE) && !rsp_valid;
  assign accept    = req_valid && req_ready;

  // Each state waits on exactly one phase edge. Rises of any other phase are
  // masked off. In IDLE the mask is empty, so a rise in the accept cycle is ignored.
  always_comb begin
    wait_mask = '0;
    case (state)
      ARM:     wait_mask = 10'b00_0000_0100;
      ADDR:    wait_mask = 10'b00_0001_0000;
      DATA:    wait_mask = 10'b00_0100_0000;
      EN:      wait_mask = 10'b01_0000_0000;
      HOLD:    wait_mask = 10'b10_0000_0000;
      default: wait_mask = '0;
    endcase
  end

  assign awaited = |(rise & wait_mask);

  // Phase history for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) clkp_q <= '0;
    else       clkp_q <= clkp;
  end

  // Request fields are captured once at accept. Later changes on the request
  // inputs have no effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_q   <= '0;
    end else if (accept) begin
      write_q  <= req_write;
      addr_a_q <= req_addrA;
      addr_b_q <= req_addrB;
      data_q   <= req_data;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state: advance one step per awaited phase rise. A watchdog abort
  // overrides the normal step.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept)  state_d = ARM;
      ARM:     if (awaited) state_d = ADDR;
      ADDR:    if (awaited) state_d = DATA;
      DATA:    if (awaited) state_d = EN;
      EN:      if (awaited) state_d = HOLD;
      HOLD:    if (awaited) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_hit) state_d = IDLE;
  end

  // Output next-values. Every bank control holds its value except on the
  // awaited rise of the current state. Read data is sampled from outA/outB as
  // seen just before the ph8 edge, while ReadEn is still high.
  always_comb begin
    word_a_d     = wordA;
    word_b_d     = wordB;
    sram_in_d    = sram_in;
    read_en_d    = ReadEn;
    write_en_d   = WriteEn;
    rsp_valid_d  = 1'b0;
    rsp_data_a_d = rsp_dataA;
    rsp_data_b_d = rsp_dataB;
    if (awaited) begin
      case (state)
        ARM: begin
          word_a_d = WORD_ONE << addr_a_q;
          word_b_d = WORD_ONE << addr_b_q;
        end
        ADDR: begin
          sram_in_d = write_q ? data_q : '0;
        end
        DATA: begin
          if (!write_q) read_en_d = 1'b1;
        end
        EN: begin
          if (write_q) begin
            write_en_d = 1'b1;
          end else begin
            read_en_d    = 1'b0;
            rsp_data_a_d = outA;
            rsp_data_b_d = outB;
          end
        end
        HOLD: begin
          write_en_d  = 1'b0;
          read_en_d   = 1'b0;
          word_a_d    = '0;
          word_b_d    = '0;
          sram_in_d   = '0;
          rsp_valid_d = 1'b1;
        end
        default: begin
          rsp_valid_d = 1'b0;
        end
      endcase
    end
    if (tmo_hit) begin
      word_a_d    = '0;
      word_b_d    = '0;
      sram_in_d   = '0;
      read_en_d   = 1'b0;
      write_en_d  = 1'b0;
      rsp_valid_d = 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wordA     <= '0;
      wordB     <= '0;
      sram_in   <= '0;
      ReadEn    <= 1'b0;
      WriteEn   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dataA <= '0;
      rsp_dataB <= '0;
    end else begin
      wordA     <= word_a_d;
      wordB     <= word_b_d;
      sram_in   <= sram_in_d;
      ReadEn    <= read_en_d;
      WriteEn   <= write_en_d;
      rsp_valid <= rsp_valid_d;
      rsp_dataA <= rsp_data_a_d;
      rsp_dataB <= rsp_data_b_d;
    end
  end

`ifdef SRAM_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt;

  // The counter value is the number of cycles since the last accept or awaited
  // rise. The abort fires on the edge that would take it to TIMEOUT.
  assign tmo_hit = (state != IDLE) && !awaited && (tmo_cnt == CW'(TIMEOUT - 1));

  // Watchdog counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   tmo_cnt <= '0;
    else if (state == IDLE || awaited || tmo_hit) tmo_cnt <= '0;
    else                                         tmo_cnt <= tmo_cnt + CW'(1);
  end

  // Abort pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_err <= 1'b0;
    else       rsp_err <= tmo_hit;
  end
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule
